// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults and state type for the instruction fetch controller
//
// Purpose: default widths, the halt opcode and the fetch FSM state enum used
// by fetch_ctrl and anything that instantiates it.
// Ports: none (package).

package fetch_pkg;

  localparam int         DEF_ADDR_W  = 4;
  localparam int         DEF_DATA_W  = 4;
  localparam logic [3:0] DEF_HALT_OP = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with a one-word output register
//
// Purpose: walks a program counter through an external combinational
// instruction memory and presents each word on a valid/ready output register.
// Supports start, stop and redirect, with backpressure from the consumer.
// Build option: define FETCH_CTRL_HALT_EN to stop fetching after a captured
// word equal to HALT_OP (state HALTED); otherwise HALT_OP is an ordinary word.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   start        in   begin fetching at start_addr (ignored while running)
//   start_addr   in   first fetch address
//   stop         in   abort fetching, return to idle
//   redir_valid  in   redirect request (any state)
//   redir_addr   in   redirect target
//   mem_addr     out  address to instruction memory (always the pc)
//   mem_data     in   memory word for mem_addr, same cycle
//   instr_valid  out  instr/instr_pc hold a valid word
//   instr_ready  in   consumer accepts the word
//   instr        out  fetched word
//   instr_pc     out  address of instr
//   busy         out  state is RUN
//   halted       out  state is HALTED

module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               ADDR_W  = DEF_ADDR_W,
  parameter int               DATA_W  = DEF_DATA_W,
  parameter logic [DATA_W-1:0] HALT_OP = DATA_W'(DEF_HALT_OP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy,
  output logic              halted
);

`ifdef FETCH_CTRL_HALT_EN
  localparam bit HALT_ENABLE = 1'b1;
`else
  localparam bit HALT_ENABLE = 1'b0;
`endif

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [DATA_W-1:0] instr_next;
  logic [ADDR_W-1:0] instr_pc_next;
  logic              valid_next;
  logic              capture;
  logic              halt_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr       <= instr_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= valid_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    instr_next    = instr;
    instr_pc_next = instr_pc;
    valid_next    = instr_valid;
    // The output register can take a new word when empty or being emptied.
    capture  = (state == S_RUN) && (!instr_valid || instr_ready);
    halt_hit = HALT_ENABLE && (mem_data == HALT_OP);

    if (stop) begin
      state_next = S_IDLE;
      valid_next = 1'b0;
    end else if (redir_valid) begin
      // Any held word belongs to the abandoned stream.
      pc_next    = redir_addr;
      valid_next = 1'b0;
      state_next = S_RUN;
    end else if (start && (state != S_RUN)) begin
      pc_next    = start_addr;
      state_next = S_RUN;
      // A leftover word (e.g. the halt word) still completes its handshake.
      if (instr_valid && instr_ready) valid_next = 1'b0;
    end else if (capture) begin
      instr_next    = mem_data;
      instr_pc_next = pc;
      valid_next    = 1'b1;
      if (halt_hit) begin
        // pc stays on the halt word's address.
        state_next = S_HALTED;
      end else begin
        pc_next = pc + ADDR_W'(1);
      end
    end else if (instr_valid && instr_ready) begin
      valid_next = 1'b0;
    end
  end

  assign mem_addr = pc;
  assign busy     = (state == S_RUN);
  assign halted   = (state == S_HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl (directed scenarios plus random scoreboard)

module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int DW = DEF_DATA_W;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, redir_valid, instr_ready;
  logic [AW-1:0] start_addr, redir_addr, mem_addr, instr_pc;
  logic [DW-1:0] mem_data, instr;
  logic          instr_valid, busy, halted;
  logic [DW-1:0] mem [2**AW];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  fetch_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .HALT_OP(DW'(DEF_HALT_OP))
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .stop       (stop),
    .redir_valid(redir_valid),
    .redir_addr (redir_addr),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .busy       (busy),
    .halted     (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic identity_mem();
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; start_addr = AW'(5); stop = 1'b0;
    redir_valid = 1'b0; redir_addr = '0; instr_ready = 1'b1;
    tick(); tick();
    total++;
    if ({busy, halted, instr_valid, instr, instr_pc, mem_addr} !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b halted=%b valid=%b instr=%h pc=%h mem_addr=%h, need all 0",
               busy, halted, instr_valid, instr, instr_pc, mem_addr);
    end
    rst_n = 1'b1; start = 1'b0;
    tick();
  endtask

  // Start at 0 with ready high: words 0..5 on consecutive cycles.
  task automatic test_stream();
    start = 1'b1; start_addr = '0;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || instr_valid !== 1'b0 || mem_addr !== AW'(0)) begin
      bad++;
      $display("FAIL start_accept: got busy=%b valid=%b mem_addr=%h, need busy=1 valid=0 mem_addr=0",
               busy, instr_valid, mem_addr);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, DW'(k), AW'(k)}) begin
        bad++;
        $display("FAIL stream_word%0d: got valid=%b instr=%h pc=%h, need valid=1 instr=%h pc=%h",
                 k, instr_valid, instr, instr_pc, DW'(k), AW'(k));
      end
    end
  endtask

  // Word 5 held for 3 cycles, then 6 and 7 with no loss or duplication.
  task automatic test_backpressure();
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({instr_valid, instr, instr_pc, mem_addr} !== {1'b1, DW'(5), AW'(5), AW'(6)}) begin
        bad++;
        $display("FAIL backpressure_hold%0d: got valid=%b instr=%h pc=%h mem_addr=%h, need 1 5 5 6",
                 k, instr_valid, instr, instr_pc, mem_addr);
      end
    end
    instr_ready = 1'b1;
    for (int k = 6; k < 8; k++) begin
      tick();
      total++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, DW'(k), AW'(k)}) begin
        bad++;
        $display("FAIL backpressure_resume%0d: got valid=%b instr=%h pc=%h, need 1 %h %h",
                 k, instr_valid, instr, instr_pc, DW'(k), AW'(k));
      end
    end
  endtask

  task automatic test_redirect();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if (busy !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== AW'(8)) begin
      bad++;
      $display("FAIL stop_idle: got busy=%b valid=%b mem_addr=%h, need 0 0 8", busy, instr_valid, mem_addr);
    end
    start = 1'b1; start_addr = '0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    total++;
    if ({instr_valid, instr} !== {1'b1, DW'(3)}) begin
      bad++;
      $display("FAIL redirect_pre: got valid=%b instr=%h, need 1 3", instr_valid, instr);
    end
    redir_valid = 1'b1; redir_addr = AW'(10);
    tick();
    redir_valid = 1'b0;
    total++;
    if (instr_valid !== 1'b0 || mem_addr !== AW'(10) || busy !== 1'b1) begin
      bad++;
      $display("FAIL redirect_flush: got valid=%b mem_addr=%h busy=%b, need 0 a 1", instr_valid, mem_addr, busy);
    end
    tick();
    total++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, DW'(10), AW'(10)}) begin
      bad++;
      $display("FAIL redirect_word: got valid=%b instr=%h pc=%h, need 1 a a", instr_valid, instr, instr_pc);
    end
    redir_valid = 1'b1; redir_addr = AW'(3); stop = 1'b1;
    tick();
    redir_valid = 1'b0; stop = 1'b0;
    total++;
    if ({busy, halted, instr_valid, mem_addr} !== {3'b000, AW'(11)}) begin
      bad++;
      $display("FAIL stop_over_redirect: got busy=%b halted=%b valid=%b mem_addr=%h, need 0 0 0 b",
               busy, halted, instr_valid, mem_addr);
    end
  endtask

  task automatic test_wrap_halt();
    start = 1'b1; start_addr = AW'(14);
    tick();
    start = 1'b0;
    for (int k = 14; k < 16; k++) begin
      tick();
      total++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, DW'(k), AW'(k)}) begin
        bad++;
        $display("FAIL wrap_word%0d: got valid=%b instr=%h pc=%h, need 1 %h %h",
                 k, instr_valid, instr, instr_pc, DW'(k), AW'(k));
      end
    end
`ifdef FETCH_CTRL_HALT_EN
    total++;
    if ({halted, busy, mem_addr} !== {2'b10, AW'(15)}) begin
      bad++;
      $display("FAIL halt_enter: got halted=%b busy=%b mem_addr=%h, need 1 0 f", halted, busy, mem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({instr_valid, halted, busy} !== 3'b010) begin
        bad++;
        $display("FAIL halt_quiet%0d: got valid=%b halted=%b busy=%b, need 0 1 0", k, instr_valid, halted, busy);
      end
    end
    start = 1'b1; start_addr = AW'(2);
    tick();
    start = 1'b0;
    total++;
    if ({busy, halted} !== 2'b10) begin
      bad++;
      $display("FAIL halt_restart: got busy=%b halted=%b, need 1 0", busy, halted);
    end
    tick();
    total++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, DW'(2), AW'(2)}) begin
      bad++;
      $display("FAIL halt_resume_word: got valid=%b instr=%h pc=%h, need 1 2 2", instr_valid, instr, instr_pc);
    end
`else
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if ({instr_valid, instr, instr_pc, busy, halted} !== {1'b1, DW'(k), AW'(k), 2'b10}) begin
        bad++;
        $display("FAIL wrap_after%0d: got valid=%b instr=%h pc=%h busy=%b halted=%b, need 1 %h %h 1 0",
                 k, instr_valid, instr, instr_pc, busy, halted, DW'(k), AW'(k));
      end
    end
`endif
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; start_addr = '0;
    tick();
    start = 1'b0;
    tick(); tick();
    total++;
    if (instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_pre: got valid=%b, need 1", instr_valid);
    end
    rst_n = 1'b0; start = 1'b1; start_addr = AW'(7);
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if ({busy, halted, instr_valid, instr, instr_pc, mem_addr} !== '0) begin
        bad++;
        $display("FAIL reset_mid%0d: got busy=%b halted=%b valid=%b instr=%h pc=%h mem_addr=%h, need all 0",
                 k, busy, halted, instr_valid, instr, instr_pc, mem_addr);
      end
    end
    rst_n = 1'b1; start = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got busy=%b valid=%b, need 0 0", busy, instr_valid);
    end
  endtask

  // Scoreboard: every accepted word must be the next address of the current
  // stream; a redirect restarts the stream at its target.
  task automatic test_random();
    logic [AW-1:0] exp_addr;
    logic          hs, prev_redir;
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom_range(0, 14));
    start = 1'b1; start_addr = AW'($urandom_range(0, 2**AW - 1));
    exp_addr = start_addr;
    tick();
    start = 1'b0;
    prev_redir = 1'b0;
    for (int c = 0; c < 400; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redir_valid = ($urandom_range(0, 9) == 0);
      redir_addr  = AW'($urandom_range(0, 2**AW - 1));
      hs = instr_valid && instr_ready && !redir_valid;
      if (hs) begin
        total++;
        if (instr_pc !== exp_addr || instr !== mem[exp_addr]) begin
          bad++;
          $display("FAIL rand_word c=%0d: got pc=%h instr=%h, need pc=%h instr=%h",
                   c, instr_pc, instr, exp_addr, mem[exp_addr]);
        end
        exp_addr = exp_addr + AW'(1);
      end
      if (redir_valid) exp_addr = redir_addr;
      tick();
      if (redir_valid) begin
        total++;
        if (instr_valid !== 1'b0) begin
          bad++;
          $display("FAIL rand_flush c=%0d: got valid=%b, need 0", c, instr_valid);
        end
      end else if (prev_redir) begin
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== exp_addr) begin
          bad++;
          $display("FAIL rand_redir_latency c=%0d: got valid=%b pc=%h, need 1 %h", c, instr_valid, instr_pc, exp_addr);
        end
      end
      prev_redir = redir_valid;
    end
    redir_valid = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    identity_mem();
  endtask

  initial begin
    identity_mem();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap_halt();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, instruction address width.
REQ-002 SHALL have parameter DATA_W, default 4, instruction word width (32 planned).
REQ-003 SHALL have parameter HALT_OP, default 4'hF, halt opcode.
REQ-004 SHALL use one clock; reset is synchronous and active-low; ports clk and rst_n.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 start  input  1  begin fetching at start_addr.
REQ-008 start_addr  input  ADDR_W  first fetch address.
REQ-009 stop  input  1  abort fetching, return to IDLE.
REQ-010 redir_valid  input  1  branch/jump redirect request.
REQ-011 redir_addr  input  ADDR_W  redirect target.
REQ-012 mem_addr  output  ADDR_W  address to combinational instruction memory.
REQ-013 mem_data  input  DATA_W  word returned by memory in the same cycle.
REQ-014 instr_valid  output  1  instr/instr_pc hold a valid word.
REQ-015 instr_ready  input  1  consumer accepts word.
REQ-016 instr  output  DATA_W  fetched word.
REQ-017 instr_pc  output  ADDR_W  address of instr.
REQ-018 busy  output  1  state is RUN.
REQ-019 halted  output  1  state is HALTED.

Function
REQ-020 States: IDLE, RUN, HALTED; mem_addr equals the internal pc register in all states.
REQ-021 Per-cycle priority: stop > redir_valid > start > capture/drain.
REQ-022 stop: next state IDLE, instr_valid cleared, pc retained.
REQ-023 redir_valid (any state): pc <= redir_addr, instr_valid cleared (held/in-flight word discarded), next state RUN.
REQ-024 start in IDLE or HALTED: pc <= start_addr, next state RUN; start in RUN ignored.
REQ-025 Capture: in RUN with (!instr_valid || instr_ready) and no stop/redirect: instr <= mem_data, instr_pc <= pc, instr_valid <= 1, pc <= pc+1 modulo 2^ADDR_W (max wraps to 0).
REQ-026 Backpressure: instr_valid && !instr_ready -> instr, instr_pc, pc, instr_valid unchanged.
REQ-027 Drain: instr_valid && instr_ready with no capture -> instr_valid <= 0.
REQ-028 Latency: start accepted cycle N -> instr_valid cycle N+2 with mem[start_addr]; then one word per cycle while instr_ready high.
REQ-029 Redirect at cycle N -> first word from redir_addr valid at N+2; nothing from the old stream after N.

Reset
REQ-030 rst_n low at a clock edge: state IDLE, pc 0, instr_valid 0, instr 0, instr_pc 0, busy 0, halted 0; overrides all inputs, including mid-fetch.

Configuration
REQ-031 Macro FETCH_CTRL_HALT_EN SHALL control halt detection.
REQ-032 Defined: a capture with mem_data == HALT_OP delivers that word normally, sets state HALTED, pc holds halt address; no further captures until start or redirect.
REQ-033 Undefined: HALT_OP is an ordinary word, HALTED unreachable, halted constant 0.

Structure
REQ-034 Package fetch_pkg SHALL hold ADDR_W/DATA_W defaults, HALT_OP and the state enum typedef.
REQ-035 No sub-module; the instruction memory is external, connected via mem_addr/mem_data.

Verification (memory preloaded word i = i)
REQ-036 Reset then start, start_addr 0, instr_ready 1 -> instr 0,1,2,... one per cycle from 2 cycles later; instr_pc matches instr.
REQ-037 instr_ready 0 for 3 cycles while instr=5 -> instr/instr_pc stay 5, pc stays 6; ready high -> 6 next cycle, no loss or duplication.
REQ-038 redir_valid with redir_addr 10 while delivering 3 -> 4 never delivered, instr 10 two cycles later; redir and stop same cycle -> IDLE, instr_valid 0.
REQ-039 Start at 14, HALT_EN off -> 14,15,0,1 (wrap); HALT_EN on -> 14,15 then halted 1, busy 0, no more words; start at 2 resumes.
REQ-040 rst_n low mid-stream with instr_valid 1 -> all outputs at reset values next cycle; start ignored while rst_n low.
